// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
// Used by display_scan_controller and seven_segment_decoder.
package display_pkg;

    // Scan sequencer states: parked, anti-ghosting gap, digit lit
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Board default: HH:MM:SS
    localparam int DEFAULT_NUM_DIGITS = 6;

    // Widest anode bus the AN_OFF helper covers
    localparam int MAX_DIGITS = 32;

    // All segments dark (common-anode, active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // All anodes released; slice to the real digit count where used
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD to seven-segment decoder for common-anode displays.
// Output is active-low with bit order g..a; any value above 9 gives a blank glyph.
module seven_segment_decoder
    import display_pkg::*;
(
    input  logic [5:0] i_value,
    output logic [6:0] o_seg_n
);

    // Pure lookup of the glyph for the requested value
    always_comb begin
        o_seg_n = SEG_BLANK;
        case (i_value)
            6'd0:    o_seg_n = 7'b1000000;
            6'd1:    o_seg_n = 7'b1111001;
            6'd2:    o_seg_n = 7'b0100100;
            6'd3:    o_seg_n = 7'b0110000;
            6'd4:    o_seg_n = 7'b0011001;
            6'd5:    o_seg_n = 7'b0010010;
            6'd6:    o_seg_n = 7'b0000010;
            6'd7:    o_seg_n = 7'b1111000;
            6'd8:    o_seg_n = 7'b0000000;
            6'd9:    o_seg_n = 7'b0010000;
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scanner driving NUM_DIGITS common-anode digits through a
// single seven_segment_decoder. Each slot opens with a dead time, the digit
// vector is snapshotted once per frame, and all pins are registered, active-low.
// Optional feature macro: DISPLAY_BLINK_EN (adds blink_mask input and a
// frame-based blink phase that suppresses masked digits every other period).
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int CNT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF_L = AN_OFF[NUM_DIGITS-1:0];

    // Reject parameter sets that cannot produce a lit phase in a slot
    generate
        if (SCAN_DIV <= DEAD_CYCLES) begin : g_badScanDiv
            $fatal(1, "display_scan_controller: SCAN_DIV must exceed DEAD_CYCLES");
        end
        if (DEAD_CYCLES < 1) begin : g_badDead
            $fatal(1, "display_scan_controller: DEAD_CYCLES must be at least 1");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_badDigits
            $fatal(1, "display_scan_controller: NUM_DIGITS out of range");
        end
        if (BLINK_FRAMES < 1) begin : g_badBlink
            $fatal(1, "display_scan_controller: BLINK_FRAMES must be at least 1");
        end
    endgenerate

    scan_state_t               r_state;
    scan_state_t               w_stateNext;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cntNext;
    logic [SLOT_W-1:0]         r_slot;
    logic [SLOT_W-1:0]         w_slotNext;
    logic                      w_capture;
    logic                      w_frameEnd;

    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_dp;

    logic [NUM_DIGITS-1:0]     r_an_n;
    logic [6:0]                r_seg_n;
    logic                      r_dp_n;
    logic                      r_frame_tick;

    logic [3:0]                w_nibble;
    logic [6:0]                w_decSeg;
    logic [NUM_DIGITS-1:0]     w_lzMask;
    logic [NUM_DIGITS-1:0]     w_blinkSupp;
    logic [NUM_DIGITS-1:0]     w_suppMask;
    logic [NUM_DIGITS-1:0]     w_anSel;
    logic                      w_slotOn;

    // Sequencer: slot timing, frame wrap, and when to take a new snapshot
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_slotNext  = r_slot;
        w_capture   = 1'b0;
        w_frameEnd  = 1'b0;
        if (!en) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
            w_slotNext  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_stateNext = ST_DEAD;
                    w_cntNext   = '0;
                    w_slotNext  = '0;
                    w_capture   = 1'b1;
                end
                ST_DEAD: begin
                    w_cntNext = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        w_stateNext = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
                        w_stateNext = ST_DEAD;
                        w_cntNext   = '0;
                        if (r_slot == SLOT_W'(NUM_DIGITS - 1)) begin
                            w_slotNext = '0;
                            w_capture  = 1'b1;
                            w_frameEnd = 1'b1;
                        end else begin
                            w_slotNext = r_slot + 1'b1;
                        end
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                    w_slotNext  = '0;
                end
            endcase
        end
    end

    // State, cycle counter and slot index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_slot  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_slot  <= w_slotNext;
        end
    end

    // Frame snapshot so a digit update never tears across one frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_dp     <= '0;
        end else if (w_capture) begin
            r_digits <= digits;
            r_dp     <= dp_in;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_DIGITS-1:0] r_blinkMask;
    logic [FRAME_W-1:0]    r_frameCnt;
    logic                  r_blinkOff;

    // Blink mask rides along with the digit snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blinkMask <= '0;
        end else if (w_capture) begin
            r_blinkMask <= blink_mask;
        end
    end

    // Frame counter flips the blink phase every BLINK_FRAMES completed frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameCnt <= '0;
            r_blinkOff <= 1'b0;
        end else if (!en) begin
            r_frameCnt <= '0;
            r_blinkOff <= 1'b0;
        end else if (w_frameEnd) begin
            if (r_frameCnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                r_frameCnt <= '0;
                r_blinkOff <= ~r_blinkOff;
            end else begin
                r_frameCnt <= r_frameCnt + 1'b1;
            end
        end
    end

    // Masked digits go dark only during the off phase
    always_comb begin
        w_blinkSupp = r_blinkOff ? r_blinkMask : '0;
    end
`else
    // Without blinking nothing is suppressed on that account
    always_comb begin
        w_blinkSupp = '0;
    end
`endif

    // Leading-zero mask: walk down from the leftmost digit until a nonzero one
    always_comb begin
        logic run;
        w_lzMask = '0;
        run      = lz_blank;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run         = run & (r_digits[4*k +: 4] == 4'd0);
            w_lzMask[k] = run;
        end
    end

    // Current slot's glyph source, anode pattern and whether it may light
    always_comb begin
        w_suppMask       = w_lzMask | w_blinkSupp;
        w_nibble         = r_digits[{r_slot, 2'b00} +: 4];
        w_anSel          = AN_OFF_L;
        w_anSel[r_slot]  = 1'b0;
        w_slotOn         = (r_state == ST_DRIVE) && !w_suppMask[r_slot];
    end

    seven_segment_decoder u_decoder (
        .i_value ({2'b00, w_nibble}),
        .o_seg_n (w_decSeg)
    );

    // Registered pins: one cycle behind the sequencer, dark unless a slot is lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n       <= AN_OFF_L;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slotOn) begin
                r_an_n  <= w_anSel;
                r_seg_n <= w_decSeg;
                r_dp_n  <= ~r_dp[r_slot];
            end else begin
                r_an_n  <= AN_OFF_L;
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end
            r_frame_tick <= w_frameEnd;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with a short scan period.
// Frame expectations are queued as each digit snapshot is driven and checked
// cycle by cycle while that frame is on the pins.
module tb_display_scan_controller;

    localparam int ND    = 6;
    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        string       name;
        logic [23:0] digits;
        logic [5:0]  dp;
        logic        lz;
        logic [5:0]  blink;
        logic [5:0]  lit;
        logic [41:0] segs;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] digits;
    logic [5:0]  dp_in;
    logic        lz_blank;
`ifdef DISPLAY_BLINK_EN
    logic [5:0]  blink_mask;
`endif
    logic [5:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    vec_t vecs[7];
    vec_t vA;
    vec_t vBlink;
    vec_t sbQ[$];
    int   total;
    int   bad;
    int   frameNo;

    display_scan_controller #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .DEAD_CYCLES  (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits     (digits),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
`ifdef DISPLAY_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a snapshot's inputs and queue what its frame should show
    task automatic applyStimulus(input vec_t v);
        digits = v.digits;
        dp_in  = v.dp;
`ifdef DISPLAY_BLINK_EN
        blink_mask = v.blink;
`endif
        sbQ.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int j, input logic [5:0] expAn,
                               input logic [6:0] expSeg, input logic expDp, input logic expTick);
        total++;
        if ({an_n, seg_n, dp_n, frame_tick} !== {expAn, expSeg, expDp, expTick}) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                     name, j, an_n, seg_n, dp_n, frame_tick, expAn, expSeg, expDp, expTick);
        end
    endtask

    // Expected pins for frame cycle j of snapshot e
    task automatic checkCycle(input int j, input vec_t e);
        int         slot;
        int         c;
        logic       lit;
        logic       offPhase;
        logic [5:0] expAn;
        logic [6:0] expSeg;
        logic       expDp;
        slot     = j / SD;
        c        = j % SD;
        offPhase = ((frameNo / BF) % 2) == 1;
        lit      = (c >= DC) && e.lit[slot] && !(offPhase && e.blink[slot]);
        expAn    = 6'b111111;
        if (lit) expAn[slot] = 1'b0;
        expSeg   = lit ? e.segs[slot*7 +: 7] : SB;
        expDp    = lit ? ~e.dp[slot] : 1'b1;
        checkOutput(e.name, j, expAn, expSeg, expDp, j == FRAME - 1);
    endtask

    task automatic stepCheck(input int j, input vec_t e);
        @(posedge clk);
        @(negedge clk);
        checkCycle(j, e);
    endtask

    task automatic stepOff(input string name);
        @(posedge clk);
        @(negedge clk);
        checkOutput(name, -1, 6'b111111, SB, 1'b1, 1'b0);
    endtask

    // Check one whole frame; optionally load the next snapshot at changeAt
    task automatic runFrame(input int changeAt, input bit haveNext, input vec_t nextVec);
        vec_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty got size=0 want size>0");
            return;
        end
        e = sbQ.pop_front();
        for (int j = 0; j < FRAME; j++) begin
            stepCheck(j, e);
            if (haveNext && j == changeAt) applyStimulus(nextVec);
            if (haveNext && j == FRAME - 1) lz_blank = nextVec.lz;
        end
        frameNo++;
    endtask

    initial begin
        vec_t e;
        vecs[0] = '{"count",    24'h123456, 6'b000000, 1'b0, 6'b0, 6'b111111, {S1, S2, S3, S4, S5, S6}};
        vecs[1] = '{"nines",    24'h999999, 6'b010100, 1'b0, 6'b0, 6'b111111, {S9, S9, S9, S9, S9, S9}};
        vecs[2] = '{"lz_705",   24'h000705, 6'b000000, 1'b1, 6'b0, 6'b000111, {SB, SB, SB, S7, S0, S5}};
        vecs[3] = '{"nolz_705", 24'h000705, 6'b000000, 1'b0, 6'b0, 6'b111111, {S0, S0, S0, S7, S0, S5}};
        vecs[4] = '{"lz_1000F0",24'h1000F0, 6'b100001, 1'b1, 6'b0, 6'b111111, {S1, S0, S0, S0, SB, S0}};
        vecs[5] = '{"lz_zero",  24'h000000, 6'b000000, 1'b1, 6'b0, 6'b000001, {SB, SB, SB, SB, SB, S0}};
        vecs[6] = '{"count2",   24'h123456, 6'b000000, 1'b0, 6'b0, 6'b111111, {S1, S2, S3, S4, S5, S6}};
        vA      = '{"hexA",     24'h12345A, 6'b000000, 1'b0, 6'b0, 6'b111111, {S1, S2, S3, S4, S5, SB}};
        vBlink  = '{"blink",    24'h123456, 6'b000000, 1'b0, 6'b000001, 6'b111111, {S1, S2, S3, S4, S5, S6}};

        total    = 0;
        bad      = 0;
        frameNo  = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        lz_blank = vecs[0].lz;
        applyStimulus(vecs[0]);

        $display("[TB] reset held with en=1");
        repeat (3) stepOff("reset_hold");
        rst_n = 1'b1;
        @(posedge clk);

        $display("[TB] table-driven frames");
        for (int i = 0; i < 6; i++) begin
            runFrame(FRAME - 2, 1'b1, vecs[i+1]);
        end

        $display("[TB] mid-frame digit change");
        runFrame(20, 1'b1, vecs[1]);
        runFrame(FRAME - 2, 1'b1, vecs[0]);

        $display("[TB] enable drop in slot 3");
        e = sbQ.pop_front();
        for (int j = 0; j <= 28; j++) stepCheck(j, e);
        en = 1'b0;
        stepCheck(29, e);
        repeat (3) stepOff("en_off");
        applyStimulus(vA);
        lz_blank = vA.lz;
        en       = 1'b1;
        frameNo  = 0;
        @(posedge clk);
        runFrame(FRAME - 2, 1'b1, vA);

`ifdef DISPLAY_BLINK_EN
        $display("[TB] blink phases");
        en = 1'b0;
        sbQ.delete();
        repeat (2) stepOff("blink_idle");
        applyStimulus(vBlink);
        lz_blank = vBlink.lz;
        en       = 1'b1;
        frameNo  = 0;
        @(posedge clk);
        for (int f = 0; f < 5; f++) runFrame(FRAME - 2, 1'b1, vBlink);
`endif

        $display("[TB] async reset mid-drive");
        e = sbQ.pop_front();
        for (int j = 0; j <= 12; j++) stepCheck(j, e);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 12, 6'b111111, SB, 1'b1, 1'b0);
        repeat (2) stepOff("reset_hold2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes one seven_segment_decoder instance across NUM_DIGITS common-anode digits of the HH:MM:SS display. It takes a packed BCD digit vector from the timekeeping core and scans one digit per slot. Each slot starts with an anti-ghosting dead time. The digit vector is latched at each frame start so a frame never shows a partial update. Outputs drive the board pins directly and are active-low.

Parameters:
NUM_DIGITS, 6, number of digits scanned; digit 0 is the rightmost.
SCAN_DIV, 50000, clk cycles per digit slot; must be greater than DEAD_CYCLES (elaboration-time check, fatal).
DEAD_CYCLES, 16, cycles at the start of each slot with all anodes and segments off.
BLINK_FRAMES, 64, frames per blink half-period; used only with the optional feature.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
en  in  1  scan enable.
digits  in  4*NUM_DIGITS  packed BCD; digit k is at bits [4k+3:4k].
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit).
lz_blank  in  1  leading-zero blanking enable.
an_n  out  NUM_DIGITS  anode selects, active-low.
seg_n  out  7  segments from the decoder, active-low, bit order g..a.
dp_n  out  1  decimal point, active-low.
frame_tick  out  1  one-cycle pulse on the last cycle of the last slot.

Behaviour:
- Reset values: an_n all 1, seg_n 7'b1111111, dp_n 1, frame_tick 0, shadow digits/dp 0, slot 0, cycle counter 0, state IDLE.
- FSM states: IDLE, DEAD, DRIVE.
  - IDLE -> DEAD when en=1. On this transition the shadow registers capture digits and dp_in.
  - DEAD -> DRIVE when cycle count reaches DEAD_CYCLES-1.
  - DRIVE -> DEAD when cycle count reaches SCAN_DIV-1. The cycle counter clears and the slot increments.
- Slot wrap: slot NUM_DIGITS-1 wraps to slot 0. The shadow registers re-capture on the first cycle of slot 0 and at no other time.
- en=0 in any state: the next state is IDLE, counters clear and outputs go off. When en returns to 1, the first frame starts at slot 0 with DEAD and a fresh snapshot.
- Decoder input: the slot's shadow BCD nibble, zero-extended to 6 bits. A nibble above 9 gives the decoder's blank pattern while the anode is still driven.
- Leading-zero blanking (lz_blank=1): shadow digits from NUM_DIGITS-1 downward are suppressed while zero, up to the first nonzero digit. Digit 0 is never suppressed. A suppressed slot behaves like DEAD: anode off, seg_n blank, dp_n 1.
- Output timing: an_n, seg_n and dp_n are registered. Pins reflect the state and slot of the previous cycle (latency 1).
  - In DRIVE: an_n has only bit [slot] low, and dp_n = ~dp_shadow[slot].
  - In DEAD and IDLE: all outputs are off.
- frame_tick: registered, same latency as the pins. It pulses once per NUM_DIGITS*SCAN_DIV cycles while en=1.

Optional Feature:
DISPLAY_BLINK_EN defined:
- Adds input blink_mask [NUM_DIGITS-1:0], latched into the shadow at frame start like the digit vector.
- Adds a frame counter that toggles a blink phase every BLINK_FRAMES frames; the phase resets to "on".
- During the "off" phase, masked digits are suppressed exactly as in leading-zero blanking.
Undefined: the port, the counter and the phase logic are absent, and behaviour is as above.

Decomposition:
- display_pkg holds: the state enum; SEG_BLANK = 7'b1111111; AN_OFF (all 1) helper; default NUM_DIGITS.
- Sub-module: the existing seven_segment_decoder, instantiated once. No other sub-module.

Test Plan:
1. Hold rst_n=0 with en=1 -> an_n=6'b111111, seg_n=7'b1111111, dp_n=1, frame_tick=0. Assert rst_n=0 mid-DRIVE -> outputs return to these values immediately, without waiting for a clock edge.
2. SCAN_DIV=8, DEAD_CYCLES=2, digits=BCD 123456, en=1:
   - Each slot shows 2 off cycles, then 6 cycles with an_n bit k low.
   - Slot 0 shows seg_n=7'b0000010 ('6'); slot 5 shows seg_n=7'b1111001 ('1').
   - frame_tick pulses every 48 cycles.
3. Change digits from 123456 to 999999 during slot 2 -> slots 3–5 still show 1,2,3; '9' (7'b0010000) appears only from the next frame's slot 0.
4. lz_blank=1, digits=000705 -> slots 5, 4, 3 keep an_n high. Slot 2 shows '7' (7'b1111000), slot 1 shows '0', slot 0 shows '5'. With lz_blank=0, all six digits are driven.
5. Drop en during slot 3 DRIVE -> the next cycle is IDLE and the following pin cycle is all off. Re-assert en -> 2 dead cycles, then slot 0 with a fresh snapshot. Nibble 4'hA on digit 0 -> an_n[0] low with seg_n=7'b1111111.
6. DISPLAY_BLINK_EN with BLINK_FRAMES=2 and blink_mask=6'b000001 -> digit 0 is lit for frames 0–1, suppressed for frames 2–3, then repeats. The other digits are unaffected.
